// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
//   Shared definitions for the USB low/full-speed transmit encoder:
//   FSM state encoding, SYNC pattern, bit-stuffing limit, EOP length and
//   the NRZI line-state helper.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  // NRZI: a logical 0 flips the line between J and K, a logical 1 holds it.
  // line_j = 1 means the line is in the J state.
  function automatic logic nrzi_next(input logic line_j, input logic data_bit);
    return data_bit ? line_j : ~line_j;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// flex_counter
//   Free-running period counter. Counts 0 .. rollover_val-1 while enabled and
//   flags the final cycle of every period so a consumer can act on the edge
//   that ends it.
// Ports:
//   clk           - clock, rising edge
//   n_rst         - asynchronous active-low reset
//   clear         - synchronous restart of the period (priority over enable)
//   count_enable  - advance the counter this cycle
//   rollover_val  - period length in cycles (must be >= 1)
//   rollover_flag - high in the last cycle of each period while enabled
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_reg;
  logic                    at_terminal;

  assign at_terminal = (count_reg == rollover_val - 1'b1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_enable) begin
      count_reg <= at_terminal ? '0 : count_reg + 1'b1;
    end
  end

  assign rollover_flag = count_enable && !clear && at_terminal;

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
//   Serialises a packet of bytes onto the USB D+/D- pair: internally
//   generated SYNC, LSB-first payload with bit stuffing, NRZI encoding and
//   an SE0 SE0 J end-of-packet.
// Ports:
//   clk        - clock, rising edge
//   n_rst      - asynchronous active-low reset
//   tx_start   - begin a packet (honoured only in IDLE together with tx_valid)
//   tx_data    - payload byte, sent LSB first
//   tx_valid   - tx_data/tx_last hold a valid byte
//   tx_last    - the byte on tx_data is the final one of the packet
//   tx_ready   - the byte on tx_data/tx_last is consumed on this cycle's edge
//   dplus_out  - D+ drive
//   dminus_out - D- drive
//   tx_busy    - high whenever a packet is in progress
//   tx_done    - one-cycle pulse on return to IDLE after a normal EOP
//   tx_err     - one-cycle pulse when the next byte was not available
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  ROLLOVER = CNT_W'(CLKS_PER_BIT);

  tx_state_t  state_reg;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt_reg;
  logic [2:0] ones_cnt_reg;
  logic       line_j_reg;
  logic       last_reg;
  logic       eop_pending_reg;
  logic       abort_reg;
  logic       dplus_reg;
  logic       dminus_reg;
  logic       tx_done_reg;
  logic       tx_err_reg;

  logic       start_accept;
  logic       bit_strobe;
  logic       byte_end;
  logic       pkt_end;
  logic       load_slot;
  logic       stuff_due;
  logic       tx_bit;
  logic       line_next;
  logic [2:0] ones_next;

  assign start_accept = (state_reg == IDLE) && tx_start && tx_valid;

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start_accept),
    .count_enable (state_reg != IDLE),
    .rollover_val (ROLLOVER),
    .rollover_flag(bit_strobe)
  );

  // The bit now on the line is shift_reg[0]; bit_cnt_reg is its index.
  // The SYNC pattern travels through the same shift register as payload.
  always_comb begin
    byte_end  = (bit_cnt_reg == 3'd7);
    pkt_end   = byte_end && (state_reg == DATA) && last_reg;
    load_slot = bit_strobe && byte_end &&
                ((state_reg == SYNC) || ((state_reg == DATA) && !last_reg));
    // ones_cnt_reg already includes the bit that is just finishing.
    stuff_due = (ones_cnt_reg == 3'(STUFF_LIMIT));

    // Value of the next non-stuffed bit to put on the line.
    tx_bit = 1'b0;
    case (state_reg)
      IDLE:    tx_bit = SYNC_BYTE[0];
      STUFF:   tx_bit = shift_reg[0];   // pending bit, data did not move
      default: tx_bit = byte_end ? tx_data[0] : shift_reg[1];
    endcase

    line_next = nrzi_next(line_j_reg, tx_bit);
    ones_next = tx_bit ? ones_cnt_reg + 3'd1 : 3'd0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      ones_cnt_reg    <= '0;
      line_j_reg      <= 1'b1;
      last_reg        <= 1'b0;
      eop_pending_reg <= 1'b0;
      abort_reg       <= 1'b0;
      dplus_reg       <= 1'b1;
      dminus_reg      <= 1'b0;
      tx_done_reg     <= 1'b0;
      tx_err_reg      <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      tx_err_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          dplus_reg  <= 1'b1;
          dminus_reg <= 1'b0;
          line_j_reg <= 1'b1;
          if (start_accept) begin
            state_reg       <= SYNC;
            shift_reg       <= SYNC_BYTE;
            bit_cnt_reg     <= '0;
            last_reg        <= 1'b0;
            eop_pending_reg <= 1'b0;
            abort_reg       <= 1'b0;
            ones_cnt_reg    <= ones_next;
            line_j_reg      <= line_next;
            dplus_reg       <= line_next;
            dminus_reg      <= ~line_next;
          end
        end

        SYNC, DATA: begin
          if (bit_strobe) begin
            if (load_slot && !tx_valid) begin
              // Underrun: the packet is cut short with an immediate EOP.
              tx_err_reg  <= 1'b1;
              abort_reg   <= 1'b1;
              state_reg   <= EOP_SE0;
              bit_cnt_reg <= '0;
              dplus_reg   <= 1'b0;
              dminus_reg  <= 1'b0;
            end else begin
              if (byte_end) begin
                bit_cnt_reg <= '0;
                if (!pkt_end) begin
                  shift_reg <= tx_data;
                  last_reg  <= tx_last;
                end
              end else begin
                shift_reg   <= shift_reg >> 1;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
              end

              if (stuff_due) begin
                // Stuffed zero goes out before the next bit (or the EOP).
                state_reg       <= STUFF;
                eop_pending_reg <= pkt_end;
                ones_cnt_reg    <= '0;
                line_j_reg      <= ~line_j_reg;
                dplus_reg       <= ~line_j_reg;
                dminus_reg      <= line_j_reg;
              end else if (pkt_end) begin
                state_reg  <= EOP_SE0;
                dplus_reg  <= 1'b0;
                dminus_reg <= 1'b0;
              end else begin
                state_reg    <= DATA;
                ones_cnt_reg <= ones_next;
                line_j_reg   <= line_next;
                dplus_reg    <= line_next;
                dminus_reg   <= ~line_next;
              end
            end
          end
        end

        STUFF: begin
          if (bit_strobe) begin
            if (eop_pending_reg) begin
              state_reg   <= EOP_SE0;
              bit_cnt_reg <= '0;
              dplus_reg   <= 1'b0;
              dminus_reg  <= 1'b0;
            end else begin
              state_reg    <= DATA;
              ones_cnt_reg <= ones_next;
              line_j_reg   <= line_next;
              dplus_reg    <= line_next;
              dminus_reg   <= ~line_next;
            end
          end
        end

        EOP_SE0: begin
          dplus_reg  <= 1'b0;
          dminus_reg <= 1'b0;
          if (bit_strobe) begin
            if (bit_cnt_reg == 3'(EOP_SE0_BITS - 1)) begin
              state_reg  <= EOP_J;
              dplus_reg  <= 1'b1;
              dminus_reg <= 1'b0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end

        EOP_J: begin
          dplus_reg  <= 1'b1;
          dminus_reg <= 1'b0;
          if (bit_strobe) begin
            state_reg    <= IDLE;
            tx_done_reg  <= !abort_reg;
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
            line_j_reg   <= 1'b1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          dplus_reg  <= 1'b1;
          dminus_reg <= 1'b0;
        end
      endcase
    end
  end

  // The consume handshake has to coincide with the loading edge, so it is
  // decoded from registered state rather than registered itself.
  assign tx_ready   = load_slot && tx_valid;
  assign tx_busy    = (state_reg != IDLE);
  assign dplus_out  = dplus_reg;
  assign dminus_out = dminus_reg;
  assign tx_done    = tx_done_reg;
  assign tx_err     = tx_err_reg;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder
//   Self-checking bench for usb_tx_encoder. Each packet is turned into an
//   expected line waveform by a reference model working directly on the
//   bit stream (SYNC + LSB-first payload, stuff after six ones, NRZI,
//   SE0 SE0 J), together with the expected tx_ready/tx_done/tx_err cycles.
module tb_usb_tx_encoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  usb_tx_encoder #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .dplus_out (dplus_out),
    .dminus_out(dminus_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet under test
  logic [7:0] pkt [0:7];
  int         pkt_len;
  bit         pkt_underrun;

  // Reference model results
  logic [1:0] exp_line [$];
  int         exp_ready [$];
  int         exp_err_cycle;
  int         exp_done_cycle;

  // Observations of the last packet
  logic [1:0] obs_line [0:1023];
  logic       obs_busy [0:1023];
  int         last_done;
  int         last_done_n;
  int         last_err_n;
  int         last_se0;
  int         last_ready_n;

  // Cycle c is the c-th clock period after the accepting edge.
  function automatic void build_model();
    bit         bits_q [$];
    int         ones;
    bit         stop;
    bit         b;
    bit         needs_load;
    logic [7:0] cur;
    logic       lvl;
    exp_line.delete();
    exp_ready.delete();
    exp_err_cycle = 0;
    ones = 0;
    stop = 0;
    for (int g = 0; g <= pkt_len && !stop; g++) begin
      cur = (g == 0) ? 8'h80 : pkt[g-1];
      for (int i = 0; i < 8 && !stop; i++) begin
        b = cur[i];
        bits_q.push_back(b);
        ones = b ? ones + 1 : 0;
        if (i == 7) begin
          needs_load = (g == 0) || (g < pkt_len) || pkt_underrun;
          if (needs_load) begin
            if (g < pkt_len) begin
              exp_ready.push_back(bits_q.size() * N);
            end else begin
              exp_err_cycle = bits_q.size() * N + 1;
              stop = 1;
            end
          end
        end
        if (!stop && ones == 6) begin
          bits_q.push_back(1'b0);
          ones = 0;
        end
      end
    end
    lvl = 1'b1;
    foreach (bits_q[k]) begin
      if (!bits_q[k]) lvl = ~lvl;
      exp_line.push_back({lvl, ~lvl});
    end
    exp_line.push_back(2'b00);
    exp_line.push_back(2'b00);
    exp_line.push_back(2'b10);
    exp_done_cycle = pkt_underrun ? 0 : exp_line.size() * N + 1;
  endfunction

  // Called shortly after a rising edge with the DUT idle.
  task automatic run_packet(input string name, input bit mid_start);
    int nbits;
    int last_c;
    int idx;
    int err_first;
    bit rdy;
    int got_ready [$];
    build_model();
    nbits  = exp_line.size();
    last_c = nbits * N + 4;
    idx = 0; err_first = 0;
    last_done = 0; last_done_n = 0; last_err_n = 0; last_se0 = 0;

    tx_start = 1'b1;
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = (pkt_len == 1) && !pkt_underrun;
    @(posedge clk);
    #1 tx_start = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      obs_line[c] = {dplus_out, dminus_out};
      obs_busy[c] = tx_busy;
      rdy = tx_ready;
      if (tx_ready) got_ready.push_back(c);
      if (tx_done) begin
        last_done_n++;
        if (last_done == 0) last_done = c;
      end
      if (tx_err) begin
        last_err_n++;
        if (err_first == 0) err_first = c;
      end
      if (last_se0 == 0 && {dplus_out, dminus_out} == 2'b00) last_se0 = c;
      @(posedge clk);
      #1;
      if (rdy) begin
        idx++;
        if (idx < pkt_len) begin
          tx_data = pkt[idx];
          tx_last = (idx == pkt_len - 1) && !pkt_underrun;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
      if (mid_start) tx_start = (c == 40);
    end
    tx_start = 1'b0;
    tx_valid = 1'b0;

    for (int k = 0; k < nbits; k++) begin
      check($sformatf("%s line bit%0d start", name, k), obs_line[k*N+1], exp_line[k]);
      check($sformatf("%s line bit%0d end", name, k), obs_line[k*N+N], exp_line[k]);
    end
    check({name, " idle line after"}, obs_line[last_c], 2'b10);
    check({name, " busy first"}, obs_busy[1], 1'b1);
    check({name, " busy last"}, obs_busy[nbits*N], 1'b1);
    check({name, " busy after"}, obs_busy[nbits*N+1], 1'b0);
    check({name, " ready count"}, got_ready.size(), exp_ready.size());
    for (int r = 0; r < exp_ready.size() && r < got_ready.size(); r++)
      check($sformatf("%s ready%0d cycle", name, r), got_ready[r], exp_ready[r]);
    check({name, " done count"}, last_done_n, pkt_underrun ? 0 : 1);
    check({name, " done cycle"}, last_done, exp_done_cycle);
    check({name, " err count"}, last_err_n, pkt_underrun ? 1 : 0);
    check({name, " err cycle"}, err_first, exp_err_cycle);
    last_ready_n = got_ready.size();
    $display("pkt %s len=%0d bits=%0d ready=%0d done=%0d err=%0d",
             name, pkt_len, nbits, got_ready.size(), last_done_n, last_err_n);
  endtask

  initial begin
    int busy_seen;
    int pulse_seen;
    int nonj_seen;
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset line", {dplus_out, dminus_out}, 2'b10);
    check("reset busy", tx_busy, 1'b0);
    check("reset pulses", {tx_ready, tx_done, tx_err}, 3'b000);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // tx_start without tx_valid must not start a packet
    busy_seen = 0;
    tx_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_busy) busy_seen++;
      @(posedge clk);
      #1;
    end
    tx_start = 1'b0;
    check("start w/o valid busy cycles", busy_seen, 0);
    $display("start without valid: busy cycles %0d", busy_seen);

    // Single 0x00
    pkt[0] = 8'h00; pkt_len = 1; pkt_underrun = 0;
    run_packet("byte00", 0);
    check("byte00 done latency", last_done - 1, 152);
    check("byte00 first se0", last_se0, 16*N + 1);

    // Single 0xFF: one stuff bit, 17 bit times before EOP
    pkt[0] = 8'hFF; pkt_len = 1; pkt_underrun = 0;
    run_packet("byteFF", 0);
    check("byteFF first se0", last_se0, 17*N + 1);

    // 0x3F, 0x01
    pkt[0] = 8'h3F; pkt[1] = 8'h01; pkt_len = 2; pkt_underrun = 0;
    run_packet("3F01", 0);
    check("3F01 ready pulses", last_ready_n, 2);

    // Underrun after 0x55
    pkt[0] = 8'h55; pkt_len = 1; pkt_underrun = 1;
    run_packet("underrun55", 0);
    check("underrun55 err pulses", last_err_n, 1);

    // tx_start while busy is ignored
    pkt[0] = 8'h12; pkt[1] = 8'h34; pkt_len = 2; pkt_underrun = 0;
    run_packet("midstart", 1);
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_busy) busy_seen++;
      @(posedge clk);
      #1;
    end
    check("midstart no second packet", busy_seen, 0);

    // Randomized packets
    for (int p = 0; p < 12; p++) begin
      pkt_len = $urandom_range(4, 1);
      pkt_underrun = ($urandom_range(7, 0) == 0);
      for (int i = 0; i < pkt_len; i++)
        pkt[i] = ($urandom_range(2, 0) == 0) ? 8'hFF : 8'($urandom);
      run_packet($sformatf("rand%0d", p), 0);
    end

    // Reset in the middle of a packet
    pkt[0] = 8'hA5; pkt[1] = 8'hFF; pkt_len = 2;
    tx_start = 1'b1; tx_valid = 1'b1; tx_data = pkt[0]; tx_last = 1'b0;
    @(posedge clk);
    #1 tx_start = 1'b0;
    repeat (90) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midreset line", {dplus_out, dminus_out}, 2'b10);
    check("midreset busy", tx_busy, 1'b0);
    check("midreset pulses", {tx_ready, tx_done, tx_err}, 3'b000);
    tx_valid = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    busy_seen = 0; pulse_seen = 0; nonj_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_busy) busy_seen++;
      if (tx_done || tx_err || tx_ready) pulse_seen++;
      if ({dplus_out, dminus_out} != 2'b10) nonj_seen++;
      @(posedge clk);
      #1;
    end
    check("postreset busy cycles", busy_seen, 0);
    check("postreset pulses", pulse_seen, 0);
    check("postreset non-J cycles", nonj_seen, 0);
    $display("midreset: busy=%0d pulses=%0d nonJ=%0d", busy_seen, pulse_seen, nonj_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
